// File: rtl/adf_pkg.sv
`default_nettype none
// adf_pkg: shared constants, FSM encoding and next-register priority select
// for the ADF PLL register sequencer.
package adf_pkg;

  localparam int NREG    = 6;
  localparam int WORD_W  = 32;
  localparam int IDX_W   = 3;
  localparam int SHIFT_N = 2 * WORD_W;  // two clk_2M phases per serial bit

  // Half-word addresses: 2k selects R(k)[15:0], 2k+1 selects R(k)[31:16].
  localparam logic [3:0] ADDR_FIRST = 4'd0;
  localparam logic [3:0] ADDR_LAST  = 4'(2 * NREG - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    LATCH = 3'd4,
    GAP   = 3'd5
  } state_t;

  // Highest candidate index strictly below lim; R0 is the fallback and always last.
  function automatic logic [IDX_W-1:0] pick_next(input logic [NREG-1:0] cand,
                                                 input logic [IDX_W-1:0] lim);
    pick_next = '0;
    for (int i = 1; i < NREG; i++) begin
      if (cand[i] && (IDX_W'(i) < lim)) pick_next = IDX_W'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/adf_spi_shift.sv
`default_nettype none
// adf_spi_shift: 32-bit MSB-first serialiser driving registered cs/din/sclk;
// sclk runs at clk/2 and data changes only while sclk is low.
module adf_spi_shift
  import adf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              kill_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              busy_o,
  output logic              finish_o,
  output logic              cs_o,
  output logic              din_o,
  output logic              sclk_o
);

  logic [WORD_W-1:0] sreg_q;
  logic [6:0]        cnt_q;
  logic              active_q;
  logic              cs_q;
  logic              din_q;
  logic              sclk_q;

  assign finish_o = active_q && (cnt_q == 7'(SHIFT_N));
  assign busy_o   = active_q;
  assign cs_o     = cs_q;
  assign din_o    = din_q;
  assign sclk_o   = sclk_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || kill_i) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      cs_q     <= 1'b1;
      din_q    <= 1'b0;
      sclk_q   <= 1'b0;
    end else if (load_i) begin
      sreg_q   <= word_i;
      cnt_q    <= '0;
      active_q <= 1'b1;
      cs_q     <= 1'b0;
      din_q    <= word_i[WORD_W-1];
      sclk_q   <= 1'b0;
    end else if (active_q) begin
      if (finish_o) begin
        active_q <= 1'b0;
        cs_q     <= 1'b1;
        din_q    <= 1'b0;
        sclk_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + 7'd1;
        sclk_q <= cnt_q[0];
        // Advance to the next bit on each low phase except the first one.
        if (!cnt_q[0] && (cnt_q != 7'd0)) begin
          sreg_q <= {sreg_q[WORD_W-2:0], 1'b0};
          din_q  <= sreg_q[WORD_W-2];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adf_reg_sequencer.sv
`default_nettype none
// adf_reg_sequencer: shadow registers R0..R5 for the ADF PLL, dirty tracking and
// the sequencing FSM that shifts them out R5..R0 with R0 always last.
module adf_reg_sequencer
  import adf_pkg::*;
#(
  parameter int LATCH_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic            clk_2M,
  input  logic            clrn,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [15:0]     wr_data,
  input  logic            start_full,
  input  logic            start_upd,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [NREG-1:0] dirty,
  output logic            adf_cs,
  output logic            adf_din,
  output logic            adf_sclk
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shadow_q [NREG];
  logic [NREG-1:0]   dirty_q, dirty_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  lim_q, lim_d;
  logic              full_q, full_d;
  logic [3:0]        wait_q, wait_d;
  logic              busy_q, done_q, done_d;

  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  pick;
  logic              load;
  logic              kill;
  logic              sh_busy;
  logic              sh_finish;

  assign wr_ok  = wr_en && (wr_addr >= ADDR_FIRST) && (wr_addr <= ADDR_LAST);
  assign wr_idx = wr_addr[3:1];
  assign pick   = pick_next(full_q ? {NREG{1'b1}} : dirty_q, lim_q);
  assign kill   = abort && (state_q != IDLE);

  assign busy  = busy_q;
  assign done  = done_q;
  assign dirty = dirty_q;

  always_ff @(posedge clk_2M) begin
    if (!clrn) begin
      for (int k = 0; k < NREG; k++) shadow_q[k] <= '0;
    end else if (wr_ok) begin
      if (wr_addr[0]) shadow_q[wr_idx][31:16] <= wr_data;
      else            shadow_q[wr_idx][15:0]  <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lim_d   = lim_q;
    full_d  = full_q;
    wait_d  = wait_q;
    dirty_d = dirty_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (kill) begin
      state_d = IDLE;
      // Only a word not yet latched by cs rising must be resent.
      if ((state_q == LOAD) || (state_q == SHIFT)) dirty_d[cur_q] = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!abort && (start_full || start_upd)) begin
            state_d = SEL;
            full_d  = start_full;
            lim_d   = IDX_W'(NREG);
          end
        end
        SEL: begin
          load           = 1'b1;
          cur_d          = pick;
          lim_d          = pick;
          dirty_d[pick]  = 1'b0;
          state_d        = LOAD;
        end
        LOAD: begin
          if (sh_busy) state_d = SHIFT;
        end
        SHIFT: begin
          if (sh_finish) begin
            state_d = LATCH;
            wait_d  = 4'(LATCH_CYC - 1);
          end
        end
        LATCH: begin
          if (wait_q == 4'd0) begin
            state_d = GAP;
            wait_d  = 4'(GAP_CYC - 1);
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
        GAP: begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else if (cur_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SEL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A host write always wins over the clear from a same-cycle snapshot.
    if (wr_ok) dirty_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_2M) begin
    if (!clrn) begin
      state_q <= IDLE;
      dirty_q <= {NREG{1'b1}};
      cur_q   <= '0;
      lim_q   <= '0;
      full_q  <= 1'b0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      full_q  <= full_d;
      wait_q  <= wait_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  adf_spi_shift u_shift (
    .clk_i    (clk_2M),
    .rstn_i   (clrn),
    .kill_i   (kill),
    .load_i   (load),
    .word_i   (shadow_q[pick]),
    .busy_o   (sh_busy),
    .finish_o (sh_finish),
    .cs_o     (adf_cs),
    .din_o    (adf_din),
    .sclk_o   (adf_sclk)
  );

endmodule
`default_nettype wire

// File: tb/tb_adf_reg_sequencer.sv
`default_nettype none
// tb_adf_reg_sequencer: directed bench; decodes the serial pins into words and
// compares them, latencies and flags against hand-computed values.
module tb_adf_reg_sequencer;

  logic        clk = 1'b0;
  logic        clrn, wr_en, start_full, start_upd, abort;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, done, adf_cs, adf_din, adf_sclk;
  logic [5:0]  dirty;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] words [$];
  int          wtime [$];
  logic [31:0] exp_w [$];
  logic [31:0] sh_q  = '0;
  int          nb_q  = 0;
  logic        p_cs  = 1'b1;
  logic        p_sclk = 1'b0;

  always #5 clk = ~clk;

  adf_reg_sequencer dut (
    .clk_2M    (clk),
    .clrn      (clrn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start_full(start_full),
    .start_upd (start_upd),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .dirty     (dirty),
    .adf_cs    (adf_cs),
    .adf_din   (adf_din),
    .adf_sclk  (adf_sclk)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Serial decoder: sample bits on sclk rising while cs low; keep only complete words.
  always @(negedge clk) begin
    if (!adf_cs && adf_sclk && !p_sclk) begin
      sh_q <= {sh_q[30:0], adf_din};
      nb_q <= nb_q + 1;
    end
    if (adf_cs && !p_cs) begin
      if (nb_q == 32) begin
        words.push_back(sh_q);
        wtime.push_back(cyc);
      end
      nb_q <= 0;
    end
    if (!adf_cs && p_cs) nb_q <= 0;
    p_cs   <= adf_cs;
    p_sclk <= adf_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_words(input string tag, input int base);
    check({tag, "_count"}, 32'(words.size() - base), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && (base + i) < words.size(); i++)
      check($sformatf("%s_w%0d", tag, i), words[base + i], exp_w[i]);
  endtask

  // n equals the number of clock edges since the start edge; kind: 0 none,
  // 1 start_full pulse, 2 writes R4/R1, 3 abort, 4 reset.
  task automatic run_seq(input bit full, input int kind, input int at,
                         input int budget, output int lat);
    int n;
    n = -1;
    lat = -1;
    start_full = full; start_upd = !full;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (n == 0) begin
        start_full = 1'b0; start_upd = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
      end
      if (done) begin
        lat = n;
        break;
      end
      if (n == at) begin
        case (kind)
          1: start_full = 1'b1;
          2: begin wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h1111; end
          3: abort = 1'b1;
          4: clrn = 1'b0;
          default: ;
        endcase
      end else if (n == at + 1) begin
        case (kind)
          1: start_full = 1'b0;
          2: begin wr_addr = 4'd2; wr_data = 16'h2222; end
          3: begin
            check("abort_cs", 32'(adf_cs), 32'd1);
            check("abort_sclk", 32'(adf_sclk), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_dirty", 32'(dirty), 32'h08);
            abort = 1'b0;
          end
          4: begin
            check("rst_cs", 32'(adf_cs), 32'd1);
            check("rst_sclk", 32'(adf_sclk), 32'd0);
            check("rst_din", 32'(adf_din), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_dirty", 32'(dirty), 32'h3f);
            clrn = 1'b1;
          end
          default: ;
        endcase
      end else if (n == at + 2 && kind == 2) begin
        wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    int base;
    clrn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start_full = 1'b0; start_upd = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cs", 32'(adf_cs), 32'd1);
    check("reset_sclk", 32'(adf_sclk), 32'd0);
    check("reset_din", 32'(adf_din), 32'd0);
    check("reset_dirty", 32'(dirty), 32'h3f);
    clrn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      wr(4'(2 * k), 16'(5 + k));
      wr(4'(2 * k + 1), 16'h0000);
    end
    wr(4'd12, 16'hFFFF);
    check("dirty_after_wr", 32'(dirty), 32'h3f);

    base = words.size();
    run_seq(1'b1, 0, -10, 500, lat);
    check("full_latency", 32'(lat), 32'd414);
    exp_w = '{32'hA, 32'h9, 32'h8, 32'h7, 32'h6, 32'h5};
    check_words("full", base);
    if (words.size() >= base + 2)
      check("word_spacing", 32'(wtime[base + 1] - wtime[base]), 32'd69);
    check("full_dirty", 32'(dirty), 32'h00);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);

    wr(4'd4, 16'hABCD);
    check("dirty_r2", 32'(dirty), 32'h04);
    base = words.size();
    run_seq(1'b0, 0, -10, 300, lat);
    check("upd_latency", 32'(lat), 32'd138);
    exp_w = '{32'h0000ABCD, 32'h5};
    check_words("upd", base);
    check("upd_dirty", 32'(dirty), 32'h00);

    base = words.size();
    run_seq(1'b0, 1, 10, 300, lat);
    check("r0only_latency", 32'(lat), 32'd69);
    repeat (100) @(negedge clk);
    check("no_second_busy", 32'(busy), 32'd0);
    exp_w = '{32'h5};
    check_words("r0only", base);

    base = words.size();
    run_seq(1'b1, 2, 100, 500, lat);
    check("wrmid_latency", 32'(lat), 32'd414);
    exp_w = '{32'hA, 32'h9, 32'h8, 32'h0000ABCD, 32'h00002222, 32'h5};
    check_words("wrmid", base);
    check("wrmid_dirty", 32'(dirty), 32'h10);

    base = words.size();
    run_seq(1'b1, 3, 172, 300, lat);
    check("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
    exp_w = '{32'hA, 32'h00001111};
    check_words("abort", base);

    base = words.size();
    run_seq(1'b0, 0, -10, 300, lat);
    check("resend_latency", 32'(lat), 32'd138);
    exp_w = '{32'h8, 32'h5};
    check_words("resend", base);

    base = words.size();
    run_seq(1'b1, 4, 31, 120, lat);
    check("rst_no_done", 32'(lat), 32'hFFFF_FFFF);
    base = words.size();
    run_seq(1'b1, 0, -10, 500, lat);
    check("zero_latency", 32'(lat), 32'd414);
    exp_w = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    check_words("zero", base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adf_reg_sequencer.md
Name: adf_reg_sequencer

Overview:
Programs the ADF PLL synthesizer's six 32-bit control registers (R0..R5) over its 3-wire serial interface.
- Holds a shadow copy of each register, written 16 bits at a time from the 16-bit host data bus.
- On command, shifts the registers out in R5→R0 order; R0 is always last, because writing R0 triggers the PLL's frequency update.
- Supports a full initialisation sequence and an incremental update that sends only registers changed since their last transmission.
- Sits between the host bus decode and the synthesizer pins, in the clk_2M domain.

Parameters:
- NREG, 6, number of synthesizer registers.
- LATCH_CYC, 2, clocks adf_cs is held high after each word.
- GAP_CYC, 1, idle clocks between words, after latch.

Ports:
- clk_2M  in  1  system clock; all logic on its rising edge.
- clrn  in  1  synchronous active-low reset.
- wr_en  in  1  one-cycle host write strobe.
- wr_addr  in  4  shadow half-word select: 2k = R(k)[15:0], 2k+1 = R(k)[31:16], k=0..5; values 12..15 ignored.
- wr_data  in  16  host write data.
- start_full  in  1  pulse: send all of R5..R0.
- start_upd  in  1  pulse: send dirty registers descending, then R0.
- abort  in  1  level: stop shifting immediately.
- busy  out  1  high from accepted start until the end of the sequence.
- done  out  1  one-cycle pulse when the sequence completes normally.
- dirty  out  6  per-register modified-since-last-sent flags.
- adf_cs  out  1  PLL load-enable; low while shifting, rising edge latches the word.
- adf_din  out  1  serial data, MSB first.
- adf_sclk  out  1  serial clock, clk_2M/2.

Behaviour:
Reset (clrn=0 at a clock edge):
- Shadows cleared, dirty=6'b111111.
- State IDLE, busy=0, done=0, adf_cs=1, adf_sclk=0, adf_din=0.

Shadow writes:
- wr_en with a valid address updates the addressed half-word the same edge and sets dirty[k].
- Writes are accepted in every state, including busy.

Start handling:
- Starts are accepted only in IDLE with abort=0; otherwise ignored.
- If start_full and start_upd arrive together, start_full wins.
- start_full: send list = R5,R4,R3,R2,R1,R0.
- start_upd: send list = set bits of dirty among R5..R1 in descending order, then R0 unconditionally.
- The send list is evaluated dynamically. When choosing the next word, the FSM picks the highest pending index. A write to a higher register that has not yet been sent this pass joins the list; registers already passed are not revisited.

FSM states: IDLE → SEL → LOAD → SHIFT → LATCH → GAP → SEL … → IDLE.
- SEL (1 clk): choose next index; snapshot shadow[k] into the shift register; clear dirty[k]. If a wr_en to the same k occurs in the same cycle, the snapshot takes the old value and dirty[k] stays set.
- LOAD (1 clk): adf_cs=0, adf_din=bit31, adf_sclk=0.
- SHIFT (64 clks): for bit i=31..0, phase A holds adf_sclk=0 with adf_din=bit i; phase B sets adf_sclk=1 with data held. The PLL samples on sclk rising.
- LATCH (LATCH_CYC clks): adf_cs=1, adf_sclk=0, adf_din=0.
- GAP (GAP_CYC clks).
- After R0's GAP: done=1 for one cycle, busy=0, return to IDLE.

Timing:
- One word takes 1+1+64+2+1 = 69 clks with defaults.
- start_full completes in 6×69 = 414 clks after the start edge.
- start_upd with dirty=0 sends R0 only: 69 clks.
- busy rises the clock after start is accepted and falls together with the done pulse.

Abort:
- abort=1 in any non-IDLE state: the next edge forces adf_cs=1, adf_sclk=0, adf_din=0, busy=0, state IDLE, and no done pulse.
- The dirty bit of the word in flight is set again.
- Reset mid-sequence behaves the same but also restores all reset values.

Outputs are registered; no combinational paths from inputs to the pins.

Decomposition:
- Package adf_pkg: NREG, word width 32, state enum (IDLE, SEL, LOAD, SHIFT, LATCH, GAP), half-word address constants.
- Sub-module adf_spi_shift: 32-bit shifter and bit/phase counter. Ports: load pulse, word, busy/finish, cs, din, sclk.
- Top level: shadows, dirty logic, next-index priority select, sequencing FSM.

Test Plan:
- Reset, then write R0..R5 = 32'h0000_0005 + k, then start_full → six words on the pins in order R5..R0, each 69 clks; decoded words match; done pulses at clk 414; dirty=0.
- After the above, write only R2[15:0]=16'hABCD, then start_upd → exactly two words, R2 then R0; done after 138 clks; dirty=0.
- start_upd with dirty=0 → R0 only; start_full asserted 10 clks into busy → ignored; no second sequence.
- During R4 shift in start_full, write R4 and R1 → R4 sent with its old value and dirty[4]=1 afterwards; R1 sent with its new value; dirty[1]=0.
- abort raised at bit 15 of R3 → next edge cs=1, sclk=0, busy=0, no done; dirty[3]=1; a subsequent start_upd sends R3 (full value) then R0.
- clrn=0 mid-shift → all outputs at reset values the next edge; dirty=6'b111111; shadows=0.
